fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_if.sv | 26 ++
 rtl/fetch_queue.sv | 80 ++++++++
 rtl/fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_fetch_sequencer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encoding, default parameter values and the sequential PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          DEFAULT_QDEPTH   = 2;
    localparam logic [31:0] PC_INC           = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// Fetch bus bundle: instruction-memory request/ack channel, redirect input
// and the decode-side instruction handshake.
//   master : the fetch sequencer (drives imem_req/imem_addr and inst_*)
//   slave  : memory + decode + branch unit side
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rd, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rd, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// QDEPTH-entry FIFO of {instruction, pc} pairs.
// Ports: push/push_inst/push_pc write at the tail, pop advances the head,
// flush empties the queue (wins over push/pop), head_* show the head entry
// combinationally, count is the current occupancy.
module fetch_queue #(
    parameter int QDEPTH = 2,
    parameter int CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [31:0]   push_inst,
    input  logic [31:0]   push_pc,
    input  logic          pop,
    input  logic          flush,
    output logic          head_valid,
    output logic [31:0]   head_inst,
    output logic [31:0]   head_pc,
    output logic [CW-1:0] count
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    logic [31:0]   inst_q [QDEPTH];
    logic [31:0]   inst_d [QDEPTH];
    logic [31:0]   pc_q   [QDEPTH];
    logic [31:0]   pc_d   [QDEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inst_d   = inst_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                inst_d[wr_ptr_q] = push_inst;
                pc_d[wr_ptr_q]   = push_pc;
                wr_ptr_d         = ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            inst_q   <= inst_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid = (count_q != '0);
    assign head_inst  = inst_q[rd_ptr_q];
    assign head_pc    = pc_q[rd_ptr_q];
    assign count      = count_q;
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one outstanding instruction-memory
// read at a time, queues returned words with their PC for decode, and
// handles redirects (branch/jump) including a request already in flight.
// Ports: clk, rst_n (async active-low), bus (fetch_if.master).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no request; waiting for queue space or a redirect
//   S_REQ   | live request at req_addr, response will be queued
//   S_DRAIN | request in flight was made stale by a redirect; discard it
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = DEFAULT_QDEPTH
) (
    input logic     clk,
    input logic     rst_n,
    fetch_if.master bus
);
    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          push, pop, flush;
    logic          q_valid;
    logic [31:0]   q_inst, q_pc;
    logic [CW-1:0] q_count;
    logic [31:0]   occ_now;
    logic [31:0]   target;
    logic [31:0]   pc_plus;

    assign target  = {bus.redirect_pc[31:2], 2'b00};
    assign pc_plus = fetch_pc_q + PC_INC;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        // A redirect flushes the queue, so it suppresses any pop that cycle.
        pop        = q_valid & bus.inst_ready & ~bus.redirect;
        flush      = bus.redirect;
        // Occupancy after this cycle's pop; space is reserved at issue time.
        occ_now    = 32'(q_count) - 32'(pop);

        case (state_q)
            S_IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_d = target;
                    req_addr_d = target;
                    state_d    = S_REQ;
                end else if (occ_now < 32'(QDEPTH)) begin
                    req_addr_d = fetch_pc_q;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.imem_ack) begin
                    if (bus.redirect) begin
                        fetch_pc_d = target;
                        req_addr_d = target;
                    end else begin
                        push       = 1'b1;
                        fetch_pc_d = pc_plus;
                        if (occ_now + 32'd1 < 32'(QDEPTH)) begin
                            req_addr_d = pc_plus;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end else if (bus.redirect) begin
                    fetch_pc_d = target;
                    state_d    = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.redirect) begin
                    fetch_pc_d = target;
                end
                if (bus.imem_ack) begin
                    req_addr_d = bus.redirect ? target : fetch_pc_q;
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    fetch_queue #(.QDEPTH(QDEPTH), .CW(CW)) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_inst  (bus.imem_rd),
        .push_pc    (req_addr_q),
        .pop        (pop),
        .flush      (flush),
        .head_valid (q_valid),
        .head_inst  (q_inst),
        .head_pc    (q_pc),
        .count      (q_count)
    );

    assign bus.imem_req   = (state_q != S_IDLE);
    assign bus.imem_addr  = req_addr_q;
    assign bus.inst_valid = q_valid;
    assign bus.inst       = q_inst;
    assign bus.inst_pc    = q_pc;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory, decode and redirect stimulus
// driven from fixed cycle-by-cycle vectors, outputs sampled 1ns after the
// rising edge and compared against hand-computed values.
module tb_fetch_sequencer;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fetch_if bus ();

    fetch_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n           = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rd     = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b0;
        bus.imem_ack    = 1'b0;
        bus.imem_rd     = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_req",     32'(bus.imem_req),   32'd0);
        check("rst_addr",    bus.imem_addr,       32'h0);
        check("rst_valid",   32'(bus.inst_valid), 32'd0);
        check("rst_inst",    bus.inst,            32'h0);
        check("rst_inst_pc", bus.inst_pc,         32'h0);

        // Streaming: ack the cycle after each request, decode always ready
        bus.inst_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        check("first_req",  32'(bus.imem_req), 32'd1);
        check("first_addr", bus.imem_addr,     32'h0);
        bus.imem_ack = 1'b1;
        bus.imem_rd  = ~32'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stream_valid", 32'(bus.inst_valid), 32'd1);
            check("stream_pc",    bus.inst_pc,         32'(4 * i));
            check("stream_inst",  bus.inst,            ~32'(4 * i));
            check("stream_addr",  bus.imem_addr,       32'(4 * (i + 1)));
            bus.imem_rd = ~32'(4 * (i + 1));
        end

        // Backpressure: queue fills with PC 0,4 then the fetcher idles
        do_reset();
        bus.inst_ready = 1'b0;
        tick();
        bus.imem_ack = 1'b1;
        bus.imem_rd  = ~32'h0;
        tick();
        check("bp_addr1", bus.imem_addr, 32'h4);
        bus.imem_rd = ~32'h4;
        tick();
        bus.imem_ack = 1'b0;
        check("bp_idle_req", 32'(bus.imem_req), 32'd0);
        check("bp_head_pc",  bus.inst_pc,       32'h0);
        tick();
        check("bp_still_idle", 32'(bus.imem_req), 32'd0);
        bus.inst_ready = 1'b1;
        tick();
        check("bp_resume_req",  32'(bus.imem_req), 32'd1);
        check("bp_resume_addr", bus.imem_addr,     32'h8);
        check("bp_pop_pc",      bus.inst_pc,       32'h4);
        check("bp_pop_inst",    bus.inst,          ~32'h4);
        bus.inst_ready = 1'b0;
        bus.imem_ack   = 1'b1;
        bus.imem_rd    = ~32'h8;
        tick();
        bus.imem_ack   = 1'b0;
        bus.inst_ready = 1'b1;
        tick();
        check("bp_fifo_pc",   bus.inst_pc, 32'h8);
        check("bp_fifo_inst", bus.inst,    ~32'h8);

        // Redirect while a request is pending -> drain the stale response
        do_reset();
        bus.inst_ready = 1'b0;
        tick();
        bus.imem_ack = 1'b1;
        bus.imem_rd  = ~32'h0;
        tick();
        check("dr_pre_valid", 32'(bus.inst_valid), 32'd1);
        bus.imem_ack    = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        bus.inst_ready  = 1'b1;
        tick();
        bus.redirect = 1'b0;
        check("dr_req_held",  32'(bus.imem_req),   32'd1);
        check("dr_addr_held", bus.imem_addr,       32'h4);
        check("dr_flushed",   32'(bus.inst_valid), 32'd0);
        tick();
        check("dr_wait_addr",  bus.imem_addr,       32'h4);
        check("dr_wait_valid", 32'(bus.inst_valid), 32'd0);
        bus.imem_ack = 1'b1;
        bus.imem_rd  = 32'hDEAD_BEEF;
        tick();
        check("dr_new_addr", bus.imem_addr,       32'h40);
        check("dr_discard",  32'(bus.inst_valid), 32'd0);
        bus.imem_rd = ~32'h40;
        tick();
        bus.imem_ack = 1'b0;
        check("dr_tgt_pc",   bus.inst_pc,   32'h40);
        check("dr_tgt_inst", bus.inst,      ~32'h40);
        check("dr_next",     bus.imem_addr, 32'h44);

        // Redirect coincident with ack, unaligned target
        do_reset();
        bus.inst_ready = 1'b1;
        tick();
        bus.imem_ack    = 1'b1;
        bus.imem_rd     = ~32'h0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h83;
        tick();
        bus.redirect = 1'b0;
        check("co_no_push", 32'(bus.inst_valid), 32'd0);
        check("co_addr",    bus.imem_addr,       32'h80);
        bus.imem_rd = ~32'h80;
        tick();
        check("co_pc",   bus.inst_pc,   32'h80);
        check("co_next", bus.imem_addr, 32'h84);

        // PC wrap-around at the top of the address space
        bus.imem_rd     = 32'h1234_5678;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0;
        check("wrap_addr",  bus.imem_addr,       32'hFFFF_FFFC);
        check("wrap_flush", 32'(bus.inst_valid), 32'd0);
        bus.imem_rd = ~32'hFFFF_FFFC;
        tick();
        bus.imem_ack = 1'b0;
        check("wrap_pc",   bus.inst_pc,   32'hFFFF_FFFC);
        check("wrap_next", bus.imem_addr, 32'h0);

        // Asynchronous reset during DRAIN
        do_reset();
        bus.inst_ready = 1'b0;
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        tick();
        bus.redirect = 1'b0;
        check("ar_in_drain", 32'(bus.imem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req_drop", 32'(bus.imem_req),   32'd0);
        check("ar_addr",     bus.imem_addr,       32'h0);
        check("ar_empty",    32'(bus.inst_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_refetch_req",  32'(bus.imem_req), 32'd1);
        check("ar_refetch_addr", bus.imem_addr,     32'h0);
        bus.imem_ack = 1'b1;
        bus.imem_rd  = ~32'h0;
        tick();
        bus.imem_ack = 1'b0;
        check("ar_refetch_pc",   bus.inst_pc, 32'h0);
        check("ar_refetch_inst", bus.inst,    ~32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
